// File: rtl/vector_mem_pkg.sv
// Shared types and constants for the vector load/store unit.
// Holds the sequencer state enum, memory geometry constants and a lane-slice helper.
package vector_mem_pkg;

    localparam int LANE_COUNT = 4;
    localparam int WORD_WIDTH = 64;
    localparam int MEM_ADDRESS_WIDTH = 19;
    localparam int IDX_WIDTH = $clog2(LANE_COUNT + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } vlsuState_e;

    function automatic logic [WORD_WIDTH-1:0] laneSlice(
        input logic [LANE_COUNT*WORD_WIDTH-1:0] vec,
        input logic [IDX_WIDTH-1:0] idx
    );
        return vec[idx*WORD_WIDTH +: WORD_WIDTH];
    endfunction

endpackage

// File: rtl/vector_address_gen.sv
// Element counter plus strided address accumulator (no multiplier).
// Ports: load (capture base/stride/length), advance (step one element),
// address/index of the current element, last (current element is final).
module vector_address_gen
    import vector_mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = MEM_ADDRESS_WIDTH,
    parameter int INDEX_WIDTH = IDX_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [ADDRESS_WIDTH-1:0] base,
    input  logic [ADDRESS_WIDTH-1:0] stride,
    input  logic [INDEX_WIDTH-1:0]   length,
    input  logic                     advance,
    output logic [ADDRESS_WIDTH-1:0] address,
    output logic [INDEX_WIDTH-1:0]   index,
    output logic                     last
);

    localparam logic [INDEX_WIDTH-1:0] ONE = INDEX_WIDTH'(1);

    logic [ADDRESS_WIDTH-1:0] strideReg;
    logic [INDEX_WIDTH-1:0] lengthReg;

    // Adding the two's-complement stride modulo 2^ADDRESS_WIDTH gives
    // negative strides and silent wrap-around for free.
    always_ff @(posedge clk) begin
        if (reset) begin
            address <= '0;
            index <= '0;
            strideReg <= '0;
            lengthReg <= '0;
        end else if (load) begin
            address <= base;
            index <= '0;
            strideReg <= stride;
            lengthReg <= length;
        end else if (advance) begin
            address <= address + strideReg;
            index <= index + ONE;
        end
    end

    assign last = (index == lengthReg - ONE);

endmodule

// File: rtl/vector_load_store_unit.sv
// Strided vector load/store sequencer: one element access per cycle to a 64-bit memory.
// Ports: start/isStore/baseAddress/stride/vectorLength/storeData command in; busy/done/loadData out;
// memWriteEnable/memReadAddress/memWriteAddress/memWriteData/memReadData to memory.
// Optional macro VLSU_MASK_EN adds elementMask (masked elements keep their cycle but do not access).
module vector_load_store_unit
    import vector_mem_pkg::*;
#(
    parameter int LANES = LANE_COUNT,
    parameter int DATA_WIDTH = WORD_WIDTH,
    parameter int ADDRESS_WIDTH = MEM_ADDRESS_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          isStore,
    input  logic [ADDRESS_WIDTH-1:0]      baseAddress,
    input  logic [ADDRESS_WIDTH-1:0]      stride,
    input  logic [$clog2(LANES+1)-1:0]    vectorLength,
    input  logic [LANES*DATA_WIDTH-1:0]   storeData,
`ifdef VLSU_MASK_EN
    input  logic [LANES-1:0]              elementMask,
`endif
    output logic                          busy,
    output logic                          done,
    output logic [LANES*DATA_WIDTH-1:0]   loadData,
    output logic                          memWriteEnable,
    output logic [ADDRESS_WIDTH-1:0]      memReadAddress,
    output logic [ADDRESS_WIDTH-1:0]      memWriteAddress,
    output logic [DATA_WIDTH-1:0]         memWriteData,
    input  logic [DATA_WIDTH-1:0]         memReadData
);

    localparam int VL_WIDTH = $clog2(LANES + 1);
    localparam int SEL_WIDTH = $clog2(LANES);
    localparam logic [VL_WIDTH-1:0] MAX_VL = VL_WIDTH'(LANES);

    vlsuState_e state, nextState;

    logic isStoreReg;
    logic [LANES*DATA_WIDTH-1:0] storeReg;
    logic [ADDRESS_WIDTH-1:0] readHold, writeHold, address;
    logic [VL_WIDTH-1:0] index, vlClamped;
    logic last, accept, issue, elementActive;
    logic capValid, capActive;
    logic [SEL_WIDTH-1:0] capIndex;
`ifdef VLSU_MASK_EN
    logic [LANES-1:0] maskReg;
`endif

    assign vlClamped = (vectorLength > MAX_VL) ? MAX_VL : vectorLength;
    assign accept = (state == IDLE) && start;
    assign issue = (state == RUN);

`ifdef VLSU_MASK_EN
    assign elementActive = maskReg[index[SEL_WIDTH-1:0]];
`else
    assign elementActive = 1'b1;
`endif

    vector_address_gen #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .INDEX_WIDTH(VL_WIDTH)
    ) addrGen (
        .clk(clk),
        .reset(reset),
        .load(accept),
        .base(baseAddress),
        .stride(stride),
        .length(vlClamped),
        .advance(issue),
        .address(address),
        .index(index),
        .last(last)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: if (start) nextState = (vlClamped == '0) ? DONE : RUN;
            RUN: if (last) nextState = isStoreReg ? DONE : DRAIN;
            DRAIN: nextState = DONE;
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Read data returns one cycle after its address, so each load issue
    // is remembered for one cycle and captured on the following edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            isStoreReg <= 1'b0;
            storeReg <= '0;
`ifdef VLSU_MASK_EN
            maskReg <= '0;
`endif
            readHold <= '0;
            writeHold <= '0;
            capValid <= 1'b0;
            capActive <= 1'b0;
            capIndex <= '0;
            loadData <= '0;
        end else begin
            capValid <= issue && !isStoreReg;
            capActive <= elementActive;
            capIndex <= index[SEL_WIDTH-1:0];
            if (accept) begin
                isStoreReg <= isStore;
                storeReg <= storeData;
`ifdef VLSU_MASK_EN
                maskReg <= elementMask;
`endif
                if (!isStore) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (l >= int'(vlClamped))
                            loadData[l*DATA_WIDTH +: DATA_WIDTH] <= '0;
                    end
                end
            end
            if (issue && isStoreReg) writeHold <= address;
            if (issue && !isStoreReg) readHold <= address;
            if (capValid)
                loadData[capIndex*DATA_WIDTH +: DATA_WIDTH] <=
                    capActive ? memReadData : '0;
        end
    end

    always_comb begin
        busy = (state == RUN) || (state == DRAIN);
        done = (state == DONE);
        memWriteEnable = issue && isStoreReg && elementActive;
        memWriteData = '0;
        memWriteAddress = writeHold;
        memReadAddress = readHold;
        if (issue && isStoreReg) begin
            memWriteData = laneSlice(storeReg, index);
            memWriteAddress = address;
        end
        if (issue && !isStoreReg) memReadAddress = address;
    end

endmodule

// File: tb/tb_vector_load_store_unit.sv
// Scoreboard bench for vector_load_store_unit with a one-cycle-latency memory model.
// Expected writes/read addresses are queued at command time and popped as the DUT issues them.
module tb_vector_load_store_unit;
    import vector_mem_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic isStore;
    logic [18:0] baseAddress;
    logic [18:0] stride;
    logic [2:0] vectorLength;
    logic [255:0] storeData;
`ifdef VLSU_MASK_EN
    logic [3:0] elementMask;
`endif
    logic busy;
    logic done;
    logic [255:0] loadData;
    logic memWriteEnable;
    logic [18:0] memReadAddress;
    logic [18:0] memWriteAddress;
    logic [63:0] memWriteData;
    logic [63:0] memReadData;

    vector_load_store_unit dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .isStore(isStore),
        .baseAddress(baseAddress),
        .stride(stride),
        .vectorLength(vectorLength),
        .storeData(storeData),
`ifdef VLSU_MASK_EN
        .elementMask(elementMask),
`endif
        .busy(busy),
        .done(done),
        .loadData(loadData),
        .memWriteEnable(memWriteEnable),
        .memReadAddress(memReadAddress),
        .memWriteAddress(memWriteAddress),
        .memWriteData(memWriteData),
        .memReadData(memReadData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] addr;
        logic [63:0] data;
        int cyc;
    } wrExp_t;

    wrExp_t wrQ[$];
    logic [18:0] rdQ[$];
    logic [63:0] tbMem[logic [18:0]];
    logic [63:0] refMem[logic [18:0]];
    logic [255:0] expLoad;
    int nChecks = 0;
    int nPass = 0;

    always @(posedge clk) begin
        memReadData <= tbMem.exists(memReadAddress) ? tbMem[memReadAddress] : 64'd0;
        if (memWriteEnable) tbMem[memWriteAddress] = memWriteData;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] refRead(input logic [18:0] a);
        return refMem.exists(a) ? refMem[a] : 64'd0;
    endfunction

    task automatic preload(input logic [18:0] a, input logic [63:0] v);
        tbMem[a] = v;
        refMem[a] = v;
    endtask

    task automatic checkIdleZero(input string tag);
        check({tag, ".busy"}, 256'(busy), 256'd0);
        check({tag, ".done"}, 256'(done), 256'd0);
        check({tag, ".we"}, 256'(memWriteEnable), 256'd0);
        check({tag, ".rdAddr"}, 256'(memReadAddress), 256'd0);
        check({tag, ".wrAddr"}, 256'(memWriteAddress), 256'd0);
        check({tag, ".wrData"}, 256'(memWriteData), 256'd0);
        check({tag, ".loadData"}, loadData, 256'd0);
    endtask

    // Called at a negedge; returns at a negedge with the DUT idle.
    task automatic runCmd(input logic st, input logic [18:0] b, input logic [18:0] s,
                          input logic [2:0] vl, input logic [255:0] d, input logic [3:0] mask,
                          input int pulseCycle, input int rstCycle);
        int vlc, expDone;
        logic [18:0] a;
        logic [255:0] newLoad;
        vlc = (vl > 3'd4) ? 4 : int'(vl);
        expDone = (vlc == 0) ? 1 : (st ? vlc + 1 : vlc + 2);
        a = b;
        newLoad = '0;
        for (int i = 0; i < vlc; i++) begin
            if (!st) begin
                rdQ.push_back(a);
                if (mask[i]) newLoad[i*64 +: 64] = refRead(a);
            end else if (mask[i] && (rstCycle == 0 || i + 1 <= rstCycle)) begin
                wrQ.push_back('{addr: a, data: d[i*64 +: 64], cyc: i + 1});
                refMem[a] = d[i*64 +: 64];
            end
            a = a + s;
        end
        if (!st) expLoad = newLoad;

        start = 1'b1;
        isStore = st;
        baseAddress = b;
        stride = s;
        vectorLength = vl;
        storeData = d;
`ifdef VLSU_MASK_EN
        elementMask = mask;
`endif
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= expDone + 3; c++) begin
            check($sformatf("busy@%0d", c), 256'(busy), 256'(c < expDone));
            check($sformatf("done@%0d", c), 256'(done), 256'(c == expDone));
            if (memWriteEnable) begin
                if (wrQ.size() == 0) begin
                    check($sformatf("extraWrite@%0d", c), 256'(memWriteAddress), 256'h1_0000_0000);
                end else begin
                    wrExp_t e;
                    e = wrQ.pop_front();
                    check("wrAddr", 256'(memWriteAddress), 256'(e.addr));
                    check("wrData", 256'(memWriteData), 256'(e.data));
                    check("wrCycle", 256'(c), 256'(e.cyc));
                end
            end
            if (!st && c <= vlc && rdQ.size() > 0)
                check($sformatf("rdAddr@%0d", c), 256'(memReadAddress), 256'(rdQ.pop_front()));
            if (c == rstCycle) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                expLoad = '0;
                checkIdleZero("afterReset");
                break;
            end
            start = (c == pulseCycle);
            @(negedge clk);
        end
        start = 1'b0;
        check("wrQ.left", 256'(wrQ.size()), 256'd0);
        check("rdQ.left", 256'(rdQ.size()), 256'd0);
        check("loadData", loadData, expLoad);
        wrQ.delete();
        rdQ.delete();
    endtask

    initial begin
        logic [255:0] d;
        reset = 1'b1;
        start = 1'b0;
        isStore = 1'b0;
        baseAddress = '0;
        stride = '0;
        vectorLength = '0;
        storeData = '0;
`ifdef VLSU_MASK_EN
        elementMask = '0;
`endif
        expLoad = '0;
        repeat (3) @(negedge clk);
        checkIdleZero("reset");
        reset = 1'b0;
        @(negedge clk);

        preload(19'd10, 64'hA);
        preload(19'd12, 64'hB);
        preload(19'd14, 64'hC);
        runCmd(1'b0, 19'd10, 19'd2, 3'd3, '0, 4'hF, 0, 0);
        check("load.lanes", loadData, {64'h0, 64'hC, 64'hB, 64'hA});

        d = {64'd4, 64'd3, 64'd2, 64'd1};
        runCmd(1'b1, 19'd10, 19'd1, 3'd4, d, 4'hF, 0, 0);
        runCmd(1'b0, 19'd10, 19'd1, 3'd4, '0, 4'hF, 0, 0);
        check("readback", loadData, d);

        d = {64'd0, 64'd7, 64'd6, 64'd5};
        runCmd(1'b1, 19'd1, 19'h7FFFF, 3'd3, d, 4'hF, 0, 0);
        runCmd(1'b0, 19'd1, 19'h7FFFF, 3'd3, '0, 4'hF, 0, 0);

        runCmd(1'b1, 19'd50, 19'd1, 3'd0, {4{64'hDEAD}}, 4'hF, 0, 0);
        runCmd(1'b0, 19'd50, 19'd1, 3'd0, '0, 4'hF, 0, 0);

        d = {64'h44, 64'h33, 64'h22, 64'h11};
        runCmd(1'b1, 19'd300, 19'd3, 3'd4, d, 4'hF, 2, 0);
        runCmd(1'b0, 19'd300, 19'd3, 3'd7, '0, 4'hF, 0, 0);

        d = {64'h4, 64'h3, 64'h2, 64'h1};
        runCmd(1'b1, 19'd100, 19'd1, 3'd4, d, 4'hF, 0, 2);
        runCmd(1'b0, 19'd100, 19'd1, 3'd4, '0, 4'hF, 0, 0);

        for (int k = 0; k < 6; k++) begin
            d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            runCmd(1'($urandom_range(0, 1)), 19'($urandom), 19'($urandom_range(0, 6)) - 19'd3,
                   3'($urandom_range(0, 5)), d, 4'hF, 0, 0);
        end

`ifdef VLSU_MASK_EN
        d = {64'hD, 64'hC, 64'hB, 64'hA};
        preload(19'd200, 64'h99);
        preload(19'd202, 64'h98);
        runCmd(1'b1, 19'd200, 19'd1, 3'd4, d, 4'b1010, 0, 0);
        runCmd(1'b0, 19'd200, 19'd1, 3'd4, '0, 4'b1111, 0, 0);
        check("mask.store", loadData, {64'hD, 64'h98, 64'hB, 64'h99});
        runCmd(1'b0, 19'd200, 19'd1, 3'd4, '0, 4'b0110, 0, 0);
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/vector_load_store_unit.md
Name: vector_load_store_unit

Overview:
- Sequencer directly upstream of the data memory (64-bit words, 19-bit word address, separate read/write address ports, writeEnable).
- Accepts one vector load or store command and issues one strided element access per cycle to the memory.
- Gathers load results into a full vector register image.
- Sits between the vector execute stage and the memory.

Parameters:
- LANES, 4, number of vector elements per command.
- DATA_WIDTH, 64, element width in bits; equals the memory word width.
- ADDRESS_WIDTH, 19, memory word-address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command valid; sampled only in IDLE.
- isStore  input  1  1 = store, 0 = load; captured with start.
- baseAddress  input  ADDRESS_WIDTH  address of element 0.
- stride  input  ADDRESS_WIDTH  signed two's-complement element stride, in words.
- vectorLength  input  $clog2(LANES+1)  active elements; values above LANES are clamped to LANES.
- storeData  input  LANES*DATA_WIDTH  element i = bits [i*DATA_WIDTH +: DATA_WIDTH]; captured with start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle completion pulse.
- loadData  output  LANES*DATA_WIDTH  gathered load vector; holds its value until the next accepted load.
- memWriteEnable  output  1  to memory writeEnable.
- memReadAddress  output  ADDRESS_WIDTH  to memory readAddress.
- memWriteAddress  output  ADDRESS_WIDTH  to memory writeAddress.
- memWriteData  output  DATA_WIDTH  to memory inputData.
- memReadData  input  DATA_WIDTH  from memory outputData; valid one cycle after memReadAddress is presented.

Behaviour:
- Reset values: all outputs 0, state IDLE, captured command cleared.
- States and transitions:
  - IDLE -> RUN on start (VL>0); IDLE -> DONE on start with VL=0, which performs no memory access.
  - RUN: element counter i runs 0..VL-1, one element per cycle. Address = base + i*stride, mod 2^ADDRESS_WIDTH (wrap-around is silent). The address is produced by an accumulator, not a multiplier.
  - Store in RUN: memWriteEnable=1, memWriteAddress=addr, memWriteData=element i. After the last element, go to DONE.
  - Load in RUN: memReadAddress=addr, memWriteEnable=0. After the last issue, go to DRAIN.
  - DRAIN (load only): capture the final element. Element i is captured into loadData lane i on the edge ending cycle i+2. Go to DONE.
  - DONE: done=1, busy=0; go to IDLE.
- Timing, with start accepted at edge 0:
  - Element i is issued in cycle i+1.
  - Store: done in cycle VL+1.
  - Load: done in cycle VL+2.
- loadData handling: lanes at or above VL are zeroed when a load is accepted. Stores never modify loadData.
- memWriteEnable is 0 in every state except store RUN.
- Idle outputs: memReadAddress and memWriteAddress hold their last value.
- start while busy, or while in DONE, is ignored; there is no queueing.
- reset asserted mid-command aborts immediately. Writes already issued remain in memory; loadData clears to 0.

Optional Feature:
- Macro VLSU_MASK_EN.
- When defined: adds input elementMask [LANES], captured with start.
  - A masked-off element still consumes its cycle, so timing is unchanged.
  - Store: memWriteEnable=0 in that slot.
  - Load: the lane is written with 0 instead of memReadData.
- When undefined: the port is absent and all elements below VL are active.

Decomposition:
- Package vector_mem_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - LANE_COUNT, WORD_WIDTH and MEM_ADDRESS_WIDTH constants;
  - a lane-slice helper function.
- Sub-module vector_address_gen: element counter plus address accumulator.
  - Inputs: load, base, stride, advance.
  - Outputs: address, index, last.

Test Plan:
- Store: base=10, stride=1, VL=4, data {1,2,3,4} -> writes to addresses 10,11,12,13 in cycles 1-4; done in cycle 5; memory readback matches.
- Load: base=10, stride=2, VL=3, memory preloaded 10->0xA, 12->0xB, 14->0xC -> loadData lanes {0xA,0xB,0xC,0}; done in cycle 5.
- Wrap and negative stride: base=1, stride=-1 (0x7FFFF), VL=3 -> addresses 1, 0, 0x7FFFF.
- VL=0 -> no memWriteEnable pulse; done in cycle 1. start pulsed during busy -> ignored, exactly one done.
- Reset in the cycle after the second store write (VL=4) -> only 2 writes occur, outputs 0, state IDLE; a new command then completes normally.
- VLSU_MASK_EN: store with mask 4'b1010, VL=4 -> writes only to elements 1 and 3; done still in cycle 5.
